mux_rr: RTL

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It selects one channel per cycle, either by round-robin arbitration or by a fixed select input. The chosen word goes into a single-entry output register. It is the sequential successor of the combinational 4:1 gate-level mux and sits between multiple producers and one shared consumer.

---
 rtl/mux_rr_pkg.sv | 13 +
 rtl/mux_defs.vh | 9 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/mux_rr.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mux_rr_pkg.sv
// Package for mux_rr: mode type and counter width built from the shared defines.
`include "mux_defs.vh"

package mux_rr_pkg;

    localparam int unsigned CNT_W = `MUX_CNT_W;

    typedef enum logic {
        ModeFixed = `MUX_MODE_FIXED,
        ModeRr    = `MUX_MODE_RR
    } mux_mode_e;

endpackage

// File: rtl/mux_defs.vh
// Shared mux encodings and counter width for the mux_rr block.
`ifndef MUX_DEFS_VH
`define MUX_DEFS_VH

`define MUX_MODE_FIXED 1'b0
`define MUX_MODE_RR    1'b1
`define MUX_CNT_W      16

`endif

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr (wrapping) wins.
module rr_arbiter #(
    parameter int unsigned  N  = 4,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] gidx
);

    // Two descending passes: channels above ptr overwrite those at or below it,
    // so the lowest index above ptr wins, else the lowest index at or below it.
    always_comb begin
        grant = '0;
        gidx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && int'(ptr) >= i) begin
                grant    = '0;
                grant[i] = 1'b1;
                gidx     = SW'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && int'(ptr) < i) begin
                grant    = '0;
                grant[i] = 1'b1;
                gidx     = SW'(i);
            end
        end
    end

endmodule

// File: rtl/mux_rr.sv
// N-channel registered mux with valid/ready handshakes, round-robin or fixed select.
// Define MUX_RR_CNT_EN to add the xfer_cnt output-handshake counter.
module mux_rr
    import mux_rr_pkg::*;
#(
    parameter int unsigned  N  = 4,
    parameter int unsigned  W  = 8,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  d,
    input  logic [N-1:0]    d_valid,
    output logic [N-1:0]    d_ready,
    input  logic            mode,
    input  logic [SW-1:0]   s,
    output logic [W-1:0]    y,
    output logic            y_valid,
    input  logic            y_ready,
    output logic [SW-1:0]   y_sel
`ifdef MUX_RR_CNT_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt
`endif
);

    logic [W-1:0]  y_q, y_d;
    logic          y_valid_q, y_valid_d;
    logic [SW-1:0] y_sel_q, y_sel_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic [N-1:0]  rr_grant, fix_grant, grant;
    logic [SW-1:0] rr_gidx, gidx;
    logic [W-1:0]  word;
    logic          load, xfer;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req   (d_valid),
        .ptr   (ptr_q),
        .grant (rr_grant),
        .gidx  (rr_gidx)
    );

    // Out-of-range selects match no channel and so grant nothing.
    always_comb begin
        fix_grant = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(s) == i) begin
                fix_grant[i] = d_valid[i];
            end
        end
    end

    always_comb begin
        if (mux_mode_e'(mode) == ModeRr) begin
            grant = rr_grant;
            gidx  = rr_gidx;
        end else begin
            grant = fix_grant;
            gidx  = s;
        end
    end

    assign load    = ~y_valid_q | y_ready;
    assign d_ready = (load && !rst) ? grant : '0;
    assign xfer    = |d_ready;

    always_comb begin
        word = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                word = d[i*W +: W];
            end
        end
    end

    always_comb begin
        y_d       = y_q;
        y_sel_d   = y_sel_q;
        ptr_d     = ptr_q;
        y_valid_d = y_valid_q & ~y_ready;
        if (xfer) begin
            y_d       = word;
            y_sel_d   = gidx;
            ptr_d     = gidx;
            y_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_sel_q   <= '0;
            ptr_q     <= SW'(N - 1);
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_sel_q   <= y_sel_d;
            ptr_q     <= ptr_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign y_sel   = y_sel_q;

`ifdef MUX_RR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = (y_valid_q && y_ready) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule
